// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency shift/add multiply and restoring divide.
// Define MULDIV_SIGNED_EN to enable two's-complement ops via op[2].
module muldiv_unit #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S,
    input  logic [ADR_W-1:0]  dst_adr,
    output logic              busy,
    output logic              we,
    output logic [ADR_W-1:0]  W_Adr,
    output logic [DATA_W-1:0] W,
    output logic              zf,
    output logic              nf
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   hi_nxt, lo_nxt;
    logic [1:0]          op_q;
    logic [ADR_W-1:0]    adr_q;
    logic                last;
    logic                accept;
    logic [DATA_W-1:0]   r_mag, s_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_tmp;
    logic                div_ge;
    logic [DATA_W-1:0]   div_dif;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem;
    logic [DATA_W-1:0]   res;

    assign last   = (cnt_q == CNT_W'(DATA_W - 1));
    assign accept = (state == IDLE) && start;

`ifdef MULDIV_SIGNED_EN
    logic r_sgn, s_sgn;
    logic neg_q, neg_r, dz_q;

    assign r_sgn = op[2] & R[DATA_W-1];
    assign s_sgn = op[2] & S[DATA_W-1];
    assign r_mag = r_sgn ? -R : R;
    assign s_mag = s_sgn ? -S : S;

    // Result sign flags captured with the operands at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            neg_q <= r_sgn ^ s_sgn;
            neg_r <= r_sgn;
            dz_q  <= (S == '0);
        end
    end
`else
    logic unused_op2;

    assign unused_op2 = op[2];
    assign r_mag      = R;
    assign s_mag      = S;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; busy and we follow the registered state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        we        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                we        = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: hi/lo hold product or remainder/quotient.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_tmp = {hi_q, lo_q[DATA_W-1]};
        div_ge  = (div_tmp >= {1'b0, b_q});
        div_dif = div_tmp[DATA_W-1:0] - b_q;
        if (op_q[1]) begin
            hi_nxt = div_ge ? div_dif : div_tmp[DATA_W-1:0];
            lo_nxt = {lo_q[DATA_W-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[DATA_W:1];
            lo_nxt = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // Final result selection from the last iteration's outputs.
    always_comb begin
        prod = {hi_nxt, lo_nxt};
        quo  = lo_nxt;
        rem  = hi_nxt;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -prod;
        end
        if (neg_q && !dz_q) begin
            quo = -quo;
        end
        if (neg_r) begin
            rem = -rem;
        end
`endif
        unique case (op_q)
            2'b00:   res = prod[DATA_W-1:0];
            2'b01:   res = prod[2*DATA_W-1:DATA_W];
            2'b10:   res = quo;
            default: res = rem;
        endcase
    end

    // Operand capture, iteration registers and write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            op_q  <= '0;
            adr_q <= '0;
            W     <= '0;
            W_Adr <= '0;
            zf    <= 1'b0;
            nf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= r_mag;
                        b_q   <= s_mag;
                        hi_q  <= '0;
                        lo_q  <= op[1] ? r_mag : s_mag;
                        op_q  <= op[1:0];
                        adr_q <= dst_adr;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        W     <= res;
                        W_Adr <= adr_q;
                        zf    <= (res == '0);
                        nf    <= res[DATA_W-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus reset/back-to-back sequences.
// Expectations for op[2]=1 vectors depend on MULDIV_SIGNED_EN.
module tb_muldiv_unit;

    localparam int DW = 16;
    localparam int AW = 3;
`ifdef MULDIV_SIGNED_EN
    localparam bit SG = 1'b1;
`else
    localparam bit SG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] R;
    logic [DW-1:0] S;
    logic [AW-1:0] dst_adr;
    logic          busy;
    logic          we;
    logic [AW-1:0] W_Adr;
    logic [DW-1:0] W;
    logic          zf;
    logic          nf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .DATA_W(DW),
        .ADR_W (AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .R      (R),
        .S      (S),
        .dst_adr(dst_adr),
        .busy   (busy),
        .we     (we),
        .W_Adr  (W_Adr),
        .W      (W),
        .zf     (zf),
        .nf     (nf)
    );

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] r;
        logic [DW-1:0] s;
        logic [AW-1:0] adr;
        logic [DW-1:0] w;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [2:0] o, input logic [15:0] r,
                       input logic [15:0] s, input logic [2:0] a,
                       input logic [15:0] w);
        vec_t v;
        v.op  = o;
        v.r   = r;
        v.s   = s;
        v.adr = a;
        v.w   = w;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the write pulse; lat = edges after accept, 0 on timeout.
    task automatic wait_we(output int lat);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (we) lat = k;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        start   = 1'b1;
        op      = v.op;
        R       = v.r;
        S       = v.s;
        dst_adr = v.adr;
        @(posedge clk);
        #1;
        check({tag, "_busy_acc"}, busy, 1);
        @(negedge clk);
        start   = 1'b0;
        R       = ~v.r;
        S       = ~v.s;
        dst_adr = ~v.adr;
        op      = ~v.op;
        wait_we(lat);
        check({tag, "_lat"}, lat, 16);
        check({tag, "_W"}, W, v.w);
        check({tag, "_W_Adr"}, W_Adr, v.adr);
        check({tag, "_zf"}, zf, (v.w == 16'h0));
        check({tag, "_nf"}, nf, v.w[15]);
        @(posedge clk);
        #1;
        check({tag, "_we_off"}, we, 0);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        vec_t v;
        int   lat;
        int   pulses;
        int   wlat;
        logic [DW-1:0] wval;
        logic [AW-1:0] wadr;
        logic b17;

        add(3'b000, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001);
        add(3'b001, 16'hFFFF, 16'hFFFF, 3'd6, 16'hFFFE);
        add(3'b010, 16'h0064, 16'h0007, 3'd2, 16'h000E);
        add(3'b011, 16'h0064, 16'h0007, 3'd7, 16'h0002);
        add(3'b010, 16'h00AB, 16'h0000, 3'd4, 16'hFFFF);
        add(3'b011, 16'h00AB, 16'h0000, 3'd5, 16'h00AB);
        add(3'b000, 16'h0100, 16'h0100, 3'd3, 16'h0000);
        add(3'b001, 16'h0100, 16'h0100, 3'd0, 16'h0001);
        add(3'b010, 16'h8000, 16'hFFFF, 3'd1, 16'h0000);
        add(3'b011, 16'h8000, 16'hFFFF, 3'd2, 16'h8000);
        add(3'b000, 16'hFFFE, 16'h0003, 3'd3, 16'hFFFA);
        add(3'b001, 16'hFFFE, 16'h0003, 3'd4, 16'h0002);
        add(3'b000, 16'h00FF, 16'h0101, 3'd1, 16'hFFFF);
        add(3'b011, 16'hFFFF, 16'h0100, 3'd2, 16'h00FF);
        add(3'b110, 16'hFFF9, 16'h0002, 3'd5, SG ? 16'hFFFD : 16'h7FFC);
        add(3'b111, 16'hFFF9, 16'h0002, 3'd6, SG ? 16'hFFFF : 16'h0001);
        add(3'b110, 16'h8000, 16'hFFFF, 3'd7, SG ? 16'h8000 : 16'h0000);
        add(3'b111, 16'h8000, 16'hFFFF, 3'd1, SG ? 16'h0000 : 16'h8000);
        add(3'b100, 16'hFFFE, 16'h0003, 3'd2, 16'hFFFA);
        add(3'b101, 16'hFFFE, 16'h0003, 3'd3, SG ? 16'hFFFF : 16'h0002);
        add(3'b110, 16'hFFF9, 16'h0000, 3'd4, 16'hFFFF);
        add(3'b111, 16'hFFF9, 16'h0000, 3'd5, 16'hFFF9);
        add(3'b101, 16'h0007, 16'hFFFD, 3'd6, SG ? 16'hFFFF : 16'h0006);
        add(3'b110, 16'h0007, 16'hFFFE, 3'd7, SG ? 16'hFFFD : 16'h0000);
        add(3'b111, 16'h0007, 16'hFFFE, 3'd0, SG ? 16'h0001 : 16'h0007);

        reset   = 1'b1;
        start   = 1'b0;
        op      = '0;
        R       = '0;
        S       = '0;
        dst_adr = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_we", we, 0);
        check("rst_W", W, 0);
        check("rst_W_Adr", W_Adr, 0);
        check("rst_zf", zf, 0);
        check("rst_nf", nf, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i], $sformatf("v%0d", i));
        end

        // Reset five cycles into a multiply: nothing may be written.
        @(negedge clk);
        start   = 1'b1;
        op      = 3'b000;
        R       = 16'h1234;
        S       = 16'h0010;
        dst_adr = 3'd3;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_we", we, 0);
        check("midrst_W", W, 0);
        check("midrst_W_Adr", W_Adr, 0);
        check("midrst_zf", zf, 0);
        check("midrst_nf", nf, 0);
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (we) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (we) pulses++;
        end
        check("midrst_no_write", pulses, 0);
        v.op  = 3'b000;
        v.r   = 16'h1234;
        v.s   = 16'h0010;
        v.adr = 3'd3;
        v.w   = 16'h2340;
        do_op(v, "after_rst");

        // start held high while busy with wandering operands.
        @(negedge clk);
        start   = 1'b1;
        op      = 3'b000;
        R       = 16'h0003;
        S       = 16'h0005;
        dst_adr = 3'd2;
        @(posedge clk);
        #1;
        pulses = 0;
        wlat   = 0;
        wval   = '0;
        wadr   = '0;
        b17    = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 17) begin
                op      = 3'b010;
                R       = 16'd1000;
                S       = 16'd10;
                dst_adr = 3'd5;
            end else begin
                op      = 3'($urandom);
                R       = 16'($urandom);
                S       = 16'($urandom);
                dst_adr = 3'($urandom);
            end
            @(posedge clk);
            #1;
            if (we) begin
                pulses++;
                if (wlat == 0) begin
                    wlat = k;
                    wval = W;
                    wadr = W_Adr;
                end
            end
            if (k == 17) b17 = busy;
        end
        check("hold_pulses", pulses, 1);
        check("hold_lat", wlat, 16);
        check("hold_W", wval, 16'h000F);
        check("hold_W_Adr", wadr, 3'd2);
        check("hold_busy_idle", b17, 0);
        @(posedge clk);
        #1;
        check("b2b_accept", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_we(lat);
        check("b2b_lat", lat, 16);
        check("b2b_W", W, 16'h0064);
        check("b2b_W_Adr", W_Adr, 3'd5);
        check("b2b_zf", zf, 0);
        check("b2b_nf", nf, 0);
        @(posedge clk);
        #1;
        check("b2b_we_off", we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide execute unit for the 16-bit datapath.
- Sits directly downstream of the 8x16 register file read ports: consumes the R/S operands and the destination address.
- Writes its 16-bit result back through the register file write port (W, W_Adr, we) as a single-cycle write pulse.
- One shift/add or shift/subtract step per clock; fixed latency, independent of operand values.

Parameters:
- DATA_W, 16, operand/result width; iteration count equals DATA_W.
- ADR_W, 3, register address width (8 registers).

Ports:
- clk      input   1       system clock, rising-edge.
- reset    input   1       asynchronous, active-high reset.
- start    input   1       request; sampled only in IDLE.
- op       input   3       op[1:0]: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR; op[2] signed select (see Optional Feature).
- R        input   DATA_W  operand A (multiplicand / dividend), from register file R port.
- S        input   DATA_W  operand B (multiplier / divisor), from register file S port.
- dst_adr  input   ADR_W   destination register address.
- busy     output  1       high from the accept edge until return to IDLE.
- we       output  1       write-enable pulse to the register file, one cycle.
- W_Adr    output  ADR_W   write address to the register file.
- W        output  DATA_W  write data to the register file.
- zf       output  1       W == 0, updated with each write.
- nf       output  1       W[DATA_W-1], updated with each write.

Behaviour:
- Clock and reset: one clock clk. reset is asynchronous, active-high; all flops clear immediately on reset assertion.
- Reset values: state=IDLE; busy=0; we=0; W=0; W_Adr=0; zf=0; nf=0; internal accumulators=0.
- Three states: IDLE, CALC, WRITE.
  - IDLE: on a rising edge with start=1, latch R, S, op, dst_adr, then go to CALC with iteration counter=0. busy=1 after this edge.
  - CALC: one step per edge. After the 16th step (counter reaches DATA_W-1), go to WRITE.
  - WRITE: we=1 for exactly one cycle. W = selected result, W_Adr = latched dst_adr, and zf/nf reflect W. The next edge returns to IDLE with busy=0.
- Latency: start accepted at edge N. we is high between edges N+16 and N+17. busy is high for 17 cycles. The earliest next accept is edge N+18.
- start while busy (CALC or WRITE): ignored, never queued. Operand changes on R/S/op/dst_adr after acceptance have no effect.
- Multiply: unsigned shift-add into a 2*DATA_W product. MULLO returns product[15:0]; MULHI returns product[31:16].
- Divide: restoring shift-subtract. DIVQ returns the quotient; DIVR returns the remainder.
- Divide by zero: same fixed latency, no exception. Quotient = 0xFFFF; remainder = dividend.
- W and W_Adr hold their last written values outside WRITE. we is 0 in every state except WRITE.
- Reset mid-operation (any state): abort immediately; no write is issued. Outputs return to reset values.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op[2]=1 selects two's-complement operation.
  - Operands are converted to magnitudes, the unsigned core runs, then signs are applied.
  - Product sign = sign(R) XOR sign(S).
  - Quotient sign = sign(R) XOR sign(S); remainder takes the sign of the dividend.
  - Overflow case 0x8000 / 0xFFFF: quotient = 0x8000, remainder = 0.
  - Signed divide by zero: quotient = 0xFFFF, remainder = dividend.
  - Latency is unchanged.
- Not defined: op[2] is ignored and all operations are unsigned; no sign-conversion logic is synthesized.

Test Plan:
1. Reset mid-CALC: accept MULLO R=0x1234, S=0x0010, assert reset 5 cycles later -> busy=0, we never pulses, W=0, W_Adr=0; a following MULLO completes normally with W=0x2340.
2. MULLO/MULHI: R=0xFFFF, S=0xFFFF -> MULLO gives W=0x0001, nf=0, zf=0; MULHI gives W=0xFFFE, nf=1. we is high exactly 16 cycles after the accept edge, for one cycle, with W_Adr=dst_adr.
3. DIVQ/DIVR: R=100 (0x0064), S=7 -> DIVQ gives W=0x000E; DIVR gives W=0x0002. Divide by zero with R=0x00AB, S=0 -> DIVQ gives 0xFFFF, DIVR gives 0x00AB.
4. start held high through busy with changing R/S/dst_adr -> exactly one write, using the values latched at accept. Next accept at edge N+18, back-to-back results correct.
5. Zero result: MULLO R=0x0100, S=0x0100 -> W=0x0000, zf=1, nf=0.
6. MULDIV_SIGNED_EN defined, op[2]=1:
   - DIVQ 0xFFF9 (-7) / 0x0002 gives 0xFFFD (-3); DIVR gives 0xFFFF (-1).
   - DIVQ 0x8000/0xFFFF gives 0x8000.
   - MULLO 0xFFFE * 0x0003 gives 0xFFFA; MULHI gives 0xFFFF.
   - With the macro undefined, the same MULLO gives 0xFFFA and MULHI gives 0x0002.
